// File: rtl/wash_phase_sequencer_pkg.sv
// Shared types for the wash phase sequencer: phase encoding, program table
// and small helpers for program selection and phase ordering.
package wash_phase_sequencer_pkg;

  localparam int TICK_W = 8;
  localparam int NUM_PROGS = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAULT = 3'd7
  } phase_e;

  typedef struct packed {
    logic [TICK_W-1:0] wash;
    logic [TICK_W-1:0] rinse;
    logic [TICK_W-1:0] spin;
  } prog_t;

  function automatic prog_t prog_lookup(input logic [2:0] idx);
    prog_t p;
    case (idx)
      3'd0:    p = '{wash: 8'd4,  rinse: 8'd3, spin: 8'd2};
      3'd1:    p = '{wash: 8'd8,  rinse: 8'd4, spin: 8'd4};
      3'd2:    p = '{wash: 8'd12, rinse: 8'd6, spin: 8'd6};
      3'd3:    p = '{wash: 8'd6,  rinse: 8'd0, spin: 8'd8};
      3'd4:    p = '{wash: 8'd2,  rinse: 8'd2, spin: 8'd2};
      3'd5:    p = '{wash: 8'd16, rinse: 8'd8, spin: 8'd8};
      default: p = '{wash: 8'd0,  rinse: 8'd0, spin: 8'd0};
    endcase
    return p;
  endfunction

  function automatic logic is_onehot(input logic [NUM_PROGS-1:0] sel);
    return (sel != '0) && ((sel & (sel - 6'd1)) == '0);
  endfunction

  function automatic logic [2:0] onehot_index(input logic [NUM_PROGS-1:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_PROGS; k++) begin
      if (sel[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // Successor of a timed phase that ran to completion; zero-tick phases are skipped.
  function automatic phase_e next_phase(input phase_e cur, input prog_t p, input logic cancelled);
    phase_e nxt;
    case (cur)
      ST_FILL:  nxt = (p.wash != '0) ? ST_WASH : ST_DRAIN;
      ST_WASH:  nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (cancelled)            nxt = ST_IDLE;
        else if (p.rinse != '0)   nxt = ST_RINSE;
        else if (p.spin != '0)    nxt = ST_SPIN;
        else                      nxt = ST_DONE;
      end
      ST_RINSE: nxt = (p.spin != '0) ? ST_SPIN : ST_DONE;
      ST_SPIN:  nxt = ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wash_tick_timer.sv
// Phase timer: a TICK_DIV-cycle prescaler feeding a tick counter, with a
// synchronous clear and a terminal-count flag for the last cycle of the phase.
module wash_tick_timer
  import wash_phase_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [TICK_W-1:0] target,
  output logic              tick,
  output logic              expire
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]     presc;
  logic [TICK_W-1:0] cnt;

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign expire = tick && ((cnt + TICK_W'(1)) == target);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (clear) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + TICK_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/wash_phase_sequencer.sv
// Washing-machine phase sequencer: program-driven timed phases with cancel,
// out-of-balance retry and fault handling.
module wash_phase_sequencer
  import wash_phase_sequencer_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int FILL_TICKS  = 8,
  parameter int DRAIN_TICKS = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] prog_sel,
  input  logic       start,
  input  logic       coin_ok,
  input  logic       lid_closed,
  input  logic       cancel,
  input  logic       out_of_balance,
  input  logic       motor_failure,
  output logic [2:0] phase,
  output logic       valve_open,
  output logic       motor_on,
  output logic       motor_dir,
  output logic       spin_fast,
  output logic       drain_pump,
  output logic       door_lock,
  output logic       time_out,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  phase_e            state, state_n;
  logic [2:0]        prog_idx, prog_n;
  logic              cancel_flag, cancel_n;
  logic              retry_flag, retry_n;
  logic              dir;
  logic              time_out_c;
  logic              timed;
  logic              tick, expire;
  logic [TICK_W-1:0] target;
  prog_t             prog;

  assign prog  = prog_lookup(prog_idx);
  assign timed = (state >= ST_FILL) && (state <= ST_SPIN);

  // A redistribution pass through RINSE still needs a duration when the program has no rinse.
  always_comb begin
    target = '0;
    case (state)
      ST_FILL:  target = TICK_W'(FILL_TICKS);
      ST_WASH:  target = prog.wash;
      ST_DRAIN: target = TICK_W'(DRAIN_TICKS);
      ST_RINSE: target = (prog.rinse == '0) ? TICK_W'(1) : prog.rinse;
      ST_SPIN:  target = prog.spin;
      default:  target = '0;
    endcase
  end

  wash_tick_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   ((state_n != state) || !timed),
    .target  (target),
    .tick    (tick),
    .expire  (expire)
  );

  always_comb begin
    state_n    = state;
    prog_n     = prog_idx;
    cancel_n   = cancel_flag;
    retry_n    = retry_flag;
    time_out_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && coin_ok && lid_closed && is_onehot(prog_sel)) begin
          state_n = ST_FILL;
          prog_n  = onehot_index(prog_sel);
        end
      end
      ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: begin
        if (motor_failure || !lid_closed) begin
          state_n = ST_FAULT;
        end else if (cancel && (state != ST_DRAIN)) begin
          state_n  = ST_DRAIN;
          cancel_n = 1'b1;
        end else if (out_of_balance && (state == ST_SPIN)) begin
          if (retry_flag) begin
            state_n = ST_FAULT;
          end else begin
            state_n = ST_RINSE;
            retry_n = 1'b1;
          end
        end else begin
          // Cancel while draining only marks the run; the drain itself still completes.
          if (cancel) cancel_n = 1'b1;
          if (expire) begin
            time_out_c = 1'b1;
            state_n    = next_phase(state, prog, cancel_n);
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_FAULT: begin
        if (cancel && !motor_failure) state_n = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
    if (state_n == ST_IDLE) begin
      cancel_n = 1'b0;
      retry_n  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      prog_idx    <= '0;
      cancel_flag <= 1'b0;
      retry_flag  <= 1'b0;
    end else begin
      state       <= state_n;
      prog_idx    <= prog_n;
      cancel_flag <= cancel_n;
      retry_flag  <= retry_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dir <= 1'b0;
    end else if (state_n != state) begin
      dir <= 1'b0;
    end else if (tick && ((state == ST_WASH) || (state == ST_RINSE))) begin
      dir <= ~dir;
    end
  end

  assign phase      = state;
  assign valve_open = (state == ST_FILL);
  assign motor_on   = (state == ST_WASH) || (state == ST_RINSE) || (state == ST_SPIN);
  assign motor_dir  = dir && ((state == ST_WASH) || (state == ST_RINSE));
  assign spin_fast  = (state == ST_SPIN);
  assign drain_pump = (state == ST_DRAIN) || (state == ST_SPIN);
  assign busy       = (state != ST_IDLE);
  assign door_lock  = busy && (state != ST_FAULT);
  assign time_out   = time_out_c;
  assign done       = (state == ST_DONE);
  assign fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// Bench for wash_phase_sequencer: directed program runs with literal
// expectations plus randomized traffic against a cycle-level behavioural model.
module tb_wash_phase_sequencer;

  localparam int TD = 2;
  localparam int FT = 3;
  localparam int DT = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] prog_sel = '0;
  logic       start = 1'b0, coin_ok = 1'b0, lid_closed = 1'b0, cancel = 1'b0;
  logic       out_of_balance = 1'b0, motor_failure = 1'b0;
  logic [2:0] phase;
  logic       valve_open, motor_on, motor_dir, spin_fast, drain_pump, door_lock;
  logic       time_out, busy, done, fault;

  int n_checks = 0;
  int n_pass = 0;

  wash_phase_sequencer #(
    .TICK_DIV    (TD),
    .FILL_TICKS  (FT),
    .DRAIN_TICKS (DT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .prog_sel       (prog_sel),
    .start          (start),
    .coin_ok        (coin_ok),
    .lid_closed     (lid_closed),
    .cancel         (cancel),
    .out_of_balance (out_of_balance),
    .motor_failure  (motor_failure),
    .phase          (phase),
    .valve_open     (valve_open),
    .motor_on       (motor_on),
    .motor_dir      (motor_dir),
    .spin_fast      (spin_fast),
    .drain_pump     (drain_pump),
    .door_lock      (door_lock),
    .time_out       (time_out),
    .busy           (busy),
    .done           (done),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  wire [12:0] outvec = {phase, valve_open, motor_on, motor_dir, spin_fast, drain_pump,
                        door_lock, time_out, busy, done, fault};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int wash_t [6] = '{4, 8, 12, 6, 2, 16};
  int rinse_t[6] = '{3, 4, 6, 0, 2, 8};
  int spin_t [6] = '{2, 4, 6, 8, 2, 8};

  int m_ph = 0;
  int m_el = 0;
  int m_prog = 0;
  bit m_cancel = 0;
  bit m_retry = 0;

  function automatic int ticks_of(input int p);
    case (p)
      1: return FT;
      2: return wash_t[m_prog];
      3: return DT;
      4: return rinse_t[m_prog];
      5: return spin_t[m_prog];
      default: return 0;
    endcase
  endfunction

  function automatic int dur_of(input int p);
    if (p == 4 && rinse_t[m_prog] == 0) return TD;
    return ticks_of(p) * TD;
  endfunction

  function automatic int after(input int p);
    for (int q = p + 1; q < 6; q++) if (ticks_of(q) > 0) return q;
    return 6;
  endfunction

  function automatic void decide(output int nxt, output bit to, output bit sc, output bit sr);
    nxt = m_ph; to = 0; sc = 0; sr = 0;
    if (m_ph == 0) begin
      if (start && coin_ok && lid_closed && $countones(prog_sel) == 1) nxt = 1;
    end else if (m_ph >= 1 && m_ph <= 5) begin
      if (motor_failure || !lid_closed) nxt = 7;
      else if (cancel && m_ph != 3) begin nxt = 3; sc = 1; end
      else if (out_of_balance && m_ph == 5) begin
        if (m_retry) nxt = 7;
        else begin nxt = 4; sr = 1; end
      end else begin
        if (cancel) sc = 1;
        if (m_el == dur_of(m_ph) - 1) begin
          to = 1;
          nxt = (m_ph == 3 && (m_cancel || sc)) ? 0 : after(m_ph);
        end
      end
    end else if (m_ph == 6) nxt = 0;
    else if (cancel && !motor_failure) nxt = 0;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_prog = 0; m_cancel = 0; m_retry = 0;
  endtask

  task automatic model_step();
    int nxt; bit to, sc, sr;
    if (!reset_n) begin model_reset(); return; end
    decide(nxt, to, sc, sr);
    if (m_ph == 0 && nxt == 1)
      for (int k = 0; k < 6; k++) if (prog_sel[k]) m_prog = k;
    if (sc) m_cancel = 1;
    if (sr) m_retry = 1;
    if (nxt == 0) begin m_cancel = 0; m_retry = 0; end
    m_el = (nxt == m_ph) ? m_el + 1 : 0;
    m_ph = nxt;
  endtask

  function automatic logic [12:0] model_out();
    int nxt; bit to, sc, sr;
    bit dir;
    decide(nxt, to, sc, sr);
    dir = (m_ph == 2 || m_ph == 4) && (((m_el / TD) % 2) == 1);
    return {3'(m_ph), m_ph == 1, (m_ph == 2 || m_ph == 4 || m_ph == 5), dir, m_ph == 5,
            (m_ph == 3 || m_ph == 5), (m_ph != 0 && m_ph != 7), to, m_ph != 0,
            m_ph == 6, m_ph == 7};
  endfunction

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge reset_n);
    model_reset();
  end

  initial forever begin
    @(negedge clock);
    check("model_cmp", 32'(outvec), 32'(model_out()));
  end

  // ---------------- directed helpers ----------------
  int pc[8];
  int n_to, n_done;

  task automatic run_until_idle(input int max);
    bit left = 0;
    for (int k = 0; k < 8; k++) pc[k] = 0;
    n_to = 0; n_done = 0;
    for (int c = 0; c < max; c++) begin
      @(negedge clock); #1;
      if (phase != 3'd0) begin
        left = 1;
        pc[phase]++;
        n_to += int'(time_out);
        n_done += int'(done);
      end else if (left) return;
    end
    n_checks++;
    $display("FAIL run_bound: still busy after %0d cycles, required return to IDLE", max);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int max);
    for (int c = 0; c < max; c++) begin
      @(negedge clock); #1;
      if (phase == p) return;
    end
    n_checks++;
    $display("FAIL wait_phase: phase %0d not reached, got %0d", p, phase);
  endtask

  task automatic launch(input logic [5:0] sel);
    prog_sel = sel; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 32'(outvec), 32'd0);
    reset_n = 1'b1; coin_ok = 1'b1; lid_closed = 1'b1;

    // P1 full run
    launch(6'b000001);
    run_until_idle(200);
    check("p1_fill", pc[1], 6);
    check("p1_wash", pc[2], 8);
    check("p1_drain", pc[3], 4);
    check("p1_rinse", pc[4], 6);
    check("p1_spin", pc[5], 4);
    check("p1_done_len", pc[6], 1);
    check("p1_done_pulses", n_done, 1);
    check("p1_timeouts", n_to, 5);

    // P4 skips rinse
    @(posedge clock); #1;
    launch(6'b001000);
    run_until_idle(200);
    check("p4_rinse", pc[4], 0);
    check("p4_drain", pc[3], 4);
    check("p4_spin", pc[5], 16);
    check("p4_timeouts", n_to, 4);

    // two-hot select is refused
    prog_sel = 6'b000011; start = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check("bad_sel_phase", 32'(phase), 32'd0);
      check("bad_sel_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;

    // cancel during WASH
    launch(6'b000010);
    wait_phase(3'd2, 50);
    cancel = 1'b1;
    @(posedge clock); #1;
    cancel = 1'b0;
    run_until_idle(100);
    check("cancel_wash", pc[2], 0);
    check("cancel_drain", pc[3], 4);
    check("cancel_no_done", n_done, 0);

    // out_of_balance twice in SPIN
    launch(6'b010000);
    wait_phase(3'd5, 100);
    out_of_balance = 1'b1;
    @(posedge clock); #1;
    out_of_balance = 1'b0;
    check("oob1_rinse", 32'(phase), 32'd4);
    wait_phase(3'd5, 100);
    out_of_balance = 1'b1;
    @(posedge clock); #1;
    out_of_balance = 1'b0;
    check("oob2_fault", 32'(phase), 32'd7);
    check("oob2_fault_out", 32'({fault, door_lock, motor_on, drain_pump}), 32'b1000);
    cancel = 1'b1;
    @(posedge clock); #1;
    cancel = 1'b0;
    check("fault_cancel", 32'(phase), 32'd0);

    // reset while washing
    launch(6'b000100);
    wait_phase(3'd2, 50);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_wash", 32'(outvec), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 5000; c++) begin
      @(posedge clock); #1;
      start          = ($urandom_range(0, 3) == 0);
      prog_sel       = ($urandom_range(0, 7) != 0) ? (6'(1) << $urandom_range(0, 5)) : 6'($urandom);
      coin_ok        = ($urandom_range(0, 15) != 0);
      lid_closed     = ($urandom_range(0, 399) != 0);
      motor_failure  = ($urandom_range(0, 499) == 0);
      cancel         = ($urandom_range(0, 79) == 0);
      out_of_balance = ($urandom_range(0, 19) == 0);
      reset_n        = ($urandom_range(0, 1499) != 0);
    end
    @(posedge clock); #1;
    start = 1'b0; cancel = 1'b0; out_of_balance = 1'b0; motor_failure = 1'b0;
    lid_closed = 1'b1; reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_phase_sequencer.md
WASH_PHASE_SEQUENCER -- requirements
Module: wash_phase_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per phase tick (>=1).
REQ-002 Parameter FILL_TICKS, default 8, ticks spent in FILL.
REQ-003 Parameter DRAIN_TICKS, default 6, ticks spent in DRAIN.
REQ-004 clock  in  1  single system clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 prog_sel  in  6  program select; bit k-1 selects program k; valid only when exactly one-hot.
REQ-007 start  in  1  start request, sampled in IDLE.
REQ-008 coin_ok, lid_closed, cancel, out_of_balance, motor_failure  in  1 each  level inputs.
REQ-009 phase  out  3  current state encoding.
REQ-010 valve_open, motor_on, motor_dir, spin_fast, drain_pump, door_lock  out  1 each  actuator drives.
REQ-011 time_out  out  1  one-cycle pulse at each timed-phase completion.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 done, fault  out  1 each  done is a one-cycle pulse; fault is a level.

Function
REQ-014 States: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6, FAULT=7; phase equals the state code.
REQ-015 IDLE->FILL on the next edge when start=1, coin_ok=1, lid_closed=1 and prog_sel is one-hot; prog_sel is latched on that edge; start is otherwise ignored.
REQ-016 Program table, in (wash, rinse, spin) ticks: P1 (4,3,2), P2 (8,4,4), P3 (12,6,6), P4 (6,0,8), P5 (2,2,2), P6 (16,8,8).
REQ-017 Normal sequence: FILL->WASH->DRAIN->RINSE->SPIN->DONE->IDLE.
REQ-018 A phase with 0 ticks is skipped; with rinse=0, DRAIN->SPIN directly.
REQ-019 The prescaler and tick counter clear on every phase entry; each timed phase lasts exactly ticks*TICK_DIV cycles.
REQ-020 time_out pulses in the last cycle of a timed phase, coincident with the transition edge.
REQ-021 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-022 Outputs per state:
  - FILL: valve_open.
  - WASH and RINSE: motor_on; motor_dir toggles every tick, starting at 0.
  - DRAIN: drain_pump.
  - SPIN: motor_on, spin_fast, drain_pump.
  - door_lock=busy and not FAULT.
REQ-023 Event priority in active states (FILL..SPIN), highest first: motor_failure, then lid_closed=0, then cancel, then out_of_balance, then time_out.
REQ-024 motor_failure or lid_closed=0 in an active state -> FAULT next edge; fault=1, all actuators 0.
REQ-025 cancel in FILL, WASH or RINSE -> DRAIN with a cancel flag set; after that DRAIN completes -> IDLE, no done pulse.
REQ-026 cancel in DRAIN sets the flag; cancel in SPIN -> DRAIN with the flag set.
REQ-027 out_of_balance in SPIN, first occurrence -> RINSE (redistribution) with the retry flag set; second occurrence -> FAULT.
REQ-028 out_of_balance outside SPIN is ignored.
REQ-029 FAULT is left only via cancel=1 with motor_failure=0, to IDLE.
REQ-030 Cancel and retry flags clear on IDLE entry.

Reset
REQ-031 reset_n low forces IDLE, clears counters, latched program and flags, and drives all outputs 0, regardless of the state at the time (including mid-phase).

Structure
REQ-032 Shared package holds the state enum/localparams and the 6-entry program table.
REQ-033 One sub-module, wash_tick_timer: prescaler plus tick counter with clear and terminal-count outputs.

Verification (TICK_DIV=2, FILL_TICKS=3, DRAIN_TICKS=2)
REQ-034 P1, start with coin and lid: FILL 6, WASH 8, DRAIN 4, RINSE 6, SPIN 4 cycles; done pulses 1 cycle later; 5 time_out pulses.
REQ-035 P4 (rinse=0): DRAIN->SPIN directly; phase never equals 4.
REQ-036 prog_sel=6'b000011 with start -> stays IDLE, busy=0.
REQ-037 cancel in WASH -> DRAIN for 4 cycles -> IDLE, done never asserted.
REQ-038 out_of_balance in SPIN twice -> RINSE, then FAULT; cancel -> IDLE.
REQ-039 reset_n low mid-WASH -> all outputs 0 immediately; phase=0.
